// File: rtl/mem_map_pkg.sv
// Shared types and range helper for the memory address-legality checker.
package mem_map_pkg;

    // Default address width of the checked address space.
    localparam int ADDR_W_DEF = 8;

    // Largest supported address width. Range maths is done one bit wider,
    // so that BASE+SIZE can be formed without wrapping.
    localparam int ADDR_W_MAX = 12;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [ADDR_W_MAX:0]   wide_t;

    // True when base <= a < base+size. The sum is formed in the widened type,
    // so a range that runs past the top of the address space is clipped there
    // and does not wrap to 0.
    function automatic logic in_range(input wide_t a, input wide_t base, input wide_t size);
        wide_t top;
        top = base + size;
        return (a >= base) && (a < top);
    endfunction

endpackage

// File: rtl/mem_presence_map.sv
// Presence bitmap: one bit per address, loaded from parameters while reset_n
// is low and static afterwards. Provides a combinational lookup.
module mem_presence_map
    import mem_map_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_BASE  = 0,
    parameter int MEM_SIZE  = 128,
    parameter int RSVD_BASE = 0,
    parameter int RSVD_SIZE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    output logic              present
);

    localparam int DEPTH = 1 << ADDR_W;

    if ((ADDR_W < 1) || (ADDR_W > ADDR_W_MAX)) begin : g_bad_addr_w
        $error("mem_presence_map: ADDR_W must be in 1..12");
    end
    if (MEM_SIZE > DEPTH) begin : g_bad_mem_size
        $error("mem_presence_map: MEM_SIZE exceeds the address space");
    end
    if (RSVD_SIZE > DEPTH) begin : g_bad_rsvd_size
        $error("mem_presence_map: RSVD_SIZE exceeds the address space");
    end

    logic [DEPTH-1:0] map_q;
    logic [DEPTH-1:0] load_map;

    // Reset image of the map: inside the memory region and outside the hole.
    always_comb begin
        load_map = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load_map[i] = in_range(wide_t'(i), wide_t'(MEM_BASE), wide_t'(MEM_SIZE)) &&
                          !in_range(wide_t'(i), wide_t'(RSVD_BASE), wide_t'(RSVD_SIZE));
        end
    end

    // Load the map on a reset clock; it holds its contents otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            map_q <= load_map;
        end
    end

    assign present = map_q[addr];

endmodule

// File: rtl/memory_module.sv
// Address-legality checker: flags, in the same cycle, any valid request whose
// address is not a populated memory location.
module memory_module
    import mem_map_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_BASE  = 0,
    parameter int MEM_SIZE  = 128,
    parameter int RSVD_BASE = 0,
    parameter int RSVD_SIZE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              valid,
    output logic              v_err
);

    logic present;

    mem_presence_map #(
        .ADDR_W    (ADDR_W),
        .MEM_BASE  (MEM_BASE),
        .MEM_SIZE  (MEM_SIZE),
        .RSVD_BASE (RSVD_BASE),
        .RSVD_SIZE (RSVD_SIZE)
    ) u_map (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .present (present)
    );

    // Zero-latency error: gated by reset so it drops as soon as reset_n falls,
    // even in the middle of a request.
    always_comb begin
        v_err = reset_n & valid & ~present;
    end

endmodule

// File: tb/tb_memory_module.sv
// Bench for memory_module: three parameterisations (default, hole, clipped)
// driven by one stimulus stream, checked against literals and a range model.
module tb_memory_module;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] addr;
    logic       valid;
    logic       v_err0, v_err1, v_err2;

    int n_pass  = 0;
    int n_total = 0;
    bit seen_reset = 1'b0;

    always #5 clk = ~clk;

    memory_module u_dut0 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .valid(valid), .v_err(v_err0)
    );

    memory_module #(
        .MEM_BASE(16), .MEM_SIZE(32), .RSVD_BASE(24), .RSVD_SIZE(4)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .valid(valid), .v_err(v_err1)
    );

    memory_module #(
        .MEM_BASE(240), .MEM_SIZE(64)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .valid(valid), .v_err(v_err2)
    );

    // Legality from the plain range rules, using unbounded integer arithmetic.
    function automatic logic model_err(input int base, input int size, input int rb,
                                       input int rs, input int a, input logic v,
                                       input logic r);
        bit legal;
        if (!r || !v) return 1'b0;
        legal = (a >= base) && (a < base + size) && !((a >= rb) && (a < rb + rs));
        return !legal;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: v_err got %b expected %b (addr=%h valid=%b reset_n=%b)",
                      name, act, exp, addr, valid, reset_n);
    endtask

    always @(posedge clk) if (!reset_n) seen_reset <= 1'b1;

    // Every-cycle comparison against the model once a reset clock has elapsed.
    always @(negedge clk) begin
        if (seen_reset) begin
            chk("model_dflt", v_err0, model_err(0, 128, 0, 0, int'(addr), valid, reset_n));
            chk("model_hole", v_err1, model_err(16, 32, 24, 4, int'(addr), valid, reset_n));
            chk("model_clip", v_err2, model_err(240, 64, 0, 0, int'(addr), valid, reset_n));
        end
    end

    typedef struct {
        logic [7:0] a;
        logic       v;
        logic       r;
        logic       e0;
        logic       e1;
        logic       e2;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic [7:0] a, input logic v, input logic r);
        @(posedge clk);
        #1;
        addr    = a;
        valid   = v;
        reset_n = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        addr    = 8'h00;

        //          addr   v     r     dflt  hole  clip
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h18, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h1B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h2F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'hEF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].v, vecs[i].r);
            chk($sformatf("vec%0d_dflt", i), v_err0, vecs[i].e0);
            chk($sformatf("vec%0d_hole", i), v_err1, vecs[i].e1);
            chk($sformatf("vec%0d_clip", i), v_err2, vecs[i].e2);
        end

        // Full address sweep, back-to-back, valid dropped every fourth cycle;
        // checked by the every-cycle model comparison.
        for (int a = 0; a < 256; a++) begin
            drive(8'(a), (a % 4) != 3, 1'b1);
        end
        drive(8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
